// File: rtl/delay_timer_seq.sv
// Serial-programmed delay timer: detects a start pattern on x, shifts in a delay
// value MSB-first, counts (delay+1)*UNIT_CYCLES clocks, then holds done until ack.
module delay_timer_seq #(
    parameter int unsigned        PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] PATTERN     = 4'b1101,
    parameter int unsigned        DELAY_BITS  = 4,
    parameter int unsigned        UNIT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  x,
    input  logic                  ack,
    output logic                  shift_ena,
    output logic                  counting,
    output logic                  done,
    output logic [DELAY_BITS-1:0] count
);

    localparam int unsigned UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int unsigned BW = (DELAY_BITS > 1) ? $clog2(DELAY_BITS) : 1;
    localparam int unsigned VW = $clog2(PAT_LEN + 1);

    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DELAY_BITS - 1);
    localparam logic [VW-1:0] VLD_FULL  = VW'(PAT_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COUNT,
        S_WAIT
    } state_t;

    state_t                  state_q;
    logic [PAT_LEN-1:0]      hist_q;
    logic [PAT_LEN-1:0]      hist_d;
    logic [VW-1:0]           vld_q;
    logic [VW-1:0]           vld_d;
    logic                    match;
    logic [BW-1:0]           bit_q;
    logic [UW-1:0]           unit_q;
    logic [DELAY_BITS-1:0]   cnt_q;
    logic                    shift_q;
    logic                    counting_q;
    logic                    done_q;

    // Match looks at the history including the bit sampled on this edge.
    always_comb begin
        hist_d = PAT_LEN'({hist_q, x});
        vld_d  = (vld_q == VLD_FULL) ? vld_q : vld_q + 1'b1;
        match  = (hist_d == PATTERN) && (vld_d == VLD_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hist_q     <= '0;
            vld_q      <= '0;
            bit_q      <= '0;
            unit_q     <= '0;
            cnt_q      <= '0;
            shift_q    <= 1'b0;
            counting_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    hist_q <= hist_d;
                    vld_q  <= vld_d;
                    if (match) begin
                        state_q <= S_SHIFT;
                        shift_q <= 1'b1;
                        bit_q   <= '0;
                    end
                end
                S_SHIFT: begin
                    cnt_q <= DELAY_BITS'({cnt_q, x});
                    if (bit_q == BIT_LAST) begin
                        state_q    <= S_COUNT;
                        shift_q    <= 1'b0;
                        counting_q <= 1'b1;
                        unit_q     <= UNIT_LAST;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
                S_COUNT: begin
                    if (unit_q == '0) begin
                        if (cnt_q == '0) begin
                            state_q    <= S_WAIT;
                            counting_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q - 1'b1;
                            unit_q <= UNIT_LAST;
                        end
                    end else begin
                        unit_q <= unit_q - 1'b1;
                    end
                end
                S_WAIT: begin
                    // Returning to IDLE forgets all earlier bits so a fresh pattern is needed.
                    if (ack) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        hist_q  <= '0;
                        vld_q   <= '0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    shift_q    <= 1'b0;
                    counting_q <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign shift_ena = shift_q;
    assign counting  = counting_q;
    assign done      = done_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_delay_timer_seq.sv
// Scoreboarded bench for delay_timer_seq: stimulus pushes expected run timing,
// a negedge monitor measures each run and checks it when done rises.
module tb_delay_timer_seq;

    logic       clk = 1'b0;
    logic       reset, x, ack, x1, ack1;
    logic       shift_ena, counting, done;
    logic       shift_ena1, counting1, done1;
    logic [3:0] count, count1;

    always #5 clk = ~clk;

    delay_timer_seq #(.PAT_LEN(4), .PATTERN(4'b1101), .DELAY_BITS(4), .UNIT_CYCLES(4)) u0 (
        .clk(clk), .reset(reset), .x(x), .ack(ack),
        .shift_ena(shift_ena), .counting(counting), .done(done), .count(count)
    );

    delay_timer_seq #(.PAT_LEN(4), .PATTERN(4'b1101), .DELAY_BITS(4), .UNIT_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .x(x1), .ack(ack1),
        .shift_ena(shift_ena1), .counting(counting1), .done(done1), .count(count1)
    );

    typedef struct {
        int delay;
        int cycles;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int   sh_len = 0;
    int   cnt_len = 0;
    int   seq[$];
    logic done_prev = 1'b0;
    exp_t mon_e;
    int   bad_idx;

    always @(negedge clk) begin
        if (reset) begin
            sh_len = 0;
            cnt_len = 0;
            seq.delete();
            done_prev = 1'b0;
        end else begin
            chk("onehot", int'($countones({shift_ena, counting, done}) <= 1), 1);
            if (shift_ena) sh_len++;
            if (counting) begin
                cnt_len++;
                seq.push_back(int'(count));
            end
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1, expected no run pending (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("shift_len", sh_len, 4);
                    chk("count_cycles", cnt_len, mon_e.cycles);
                    bad_idx = -1;
                    foreach (seq[i])
                        if (bad_idx < 0 && seq[i] != mon_e.delay - i / 4) bad_idx = i;
                    chk("count_seq_first_bad_idx", bad_idx, -1);
                end
                sh_len = 0;
                cnt_len = 0;
                seq.delete();
            end
            done_prev = done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        x = b;
        tick();
    endtask

    task automatic send_delay(input logic [3:0] d);
        for (int i = 3; i >= 0; i--) send(d[i]);
    endtask

    task automatic expect_run(input int d, input int cyc);
        exp_t e;
        e.delay = d;
        e.cycles = cyc;
        sb.push_back(e);
    endtask

    task automatic send_pattern();
        send(1'b1);
        send(1'b1);
        send(1'b0);
        chk("no_early_match", int'(shift_ena), 0);
        send(1'b1);
        chk("match", int'(shift_ena), 1);
    endtask

    task automatic wait_done(input int limit);
        int i = 0;
        while (!done && i < limit) begin
            tick();
            i++;
        end
        chk("done_timeout", int'(done), 1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        chk("ack_drop", int'(done), 0);
        ack = 1'b0;
    endtask

    task automatic run(input logic [3:0] d, input int cyc);
        expect_run(int'(d), cyc);
        send_pattern();
        send_delay(d);
        x = 1'b0;
        wait_done(cyc + 4);
        do_ack();
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_shift"}, int'(shift_ena), 0);
        chk({name, "_counting"}, int'(counting), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_count"}, int'(count), 0);
    endtask

    task automatic no_match_bits_101();
        send(1'b1); chk("post_clear_nomatch1", int'(shift_ena), 0);
        send(1'b0); chk("post_clear_nomatch2", int'(shift_ena), 0);
        send(1'b1); chk("post_clear_nomatch3", int'(shift_ena), 0);
    endtask

    // ---------------- main sequence ----------------
    logic [7:0]  fs;
    logic [7:0]  u1_bits;
    logic [15:0] tog;

    initial begin
        reset = 1'b1; x = 1'b0; ack = 1'b0; x1 = 1'b0; ack1 = 1'b0;
        #2;
        check_idle_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        tick();

        // basic run, delay 5
        run(4'd5, 24);

        // overlap: 1,1,1,0,1
        expect_run(2, 12);
        send(1'b1); send(1'b1); send(1'b1); send(1'b0);
        chk("ovl_no_match", int'(shift_ena), 0);
        send(1'b1);
        chk("ovl_match", int'(shift_ena), 1);
        send_delay(4'd2);
        x = 1'b0;
        wait_done(16);
        do_ack();

        // false starts: 1,1,0,0,1,1,0,1
        expect_run(1, 8);
        fs = 8'b1100_1101;
        for (int i = 7; i >= 1; i--) begin
            send(fs[i]);
            chk("fs_no_match", int'(shift_ena), 0);
        end
        send(fs[0]);
        chk("fs_match", int'(shift_ena), 1);
        send_delay(4'd1);
        x = 1'b0;
        wait_done(12);
        do_ack();

        // delay boundaries
        run(4'd0, 4);
        run(4'd15, 64);

        // UNIT_CYCLES=1 instance, delay 3
        u1_bits = 8'b1101_0011;
        for (int i = 7; i >= 0; i--) begin
            x1 = u1_bits[i];
            tick();
            if (i == 4) chk("u1_shift_start", int'(shift_ena1), 1);
        end
        chk("u1_counting", int'(counting1), 1);
        chk("u1_count3", int'(count1), 3);
        tick(); chk("u1_count2", int'(count1), 2);
        tick(); chk("u1_count1", int'(count1), 1);
        tick(); chk("u1_count0", int'(count1), 0);
        chk("u1_counting_last", int'(counting1), 1);
        tick();
        chk("u1_done", int'(done1), 1);
        chk("u1_counting_off", int'(counting1), 0);
        ack1 = 1'b1;
        tick();
        chk("u1_ack_drop", int'(done1), 0);
        ack1 = 1'b0;

        // ack held through COUNT; honoured on first WAIT cycle
        expect_run(1, 8);
        send_pattern();
        ack = 1'b1;
        send_delay(4'd1);
        x = 1'b0;
        wait_done(12);
        tick();
        chk("ack_held_done_1cycle", int'(done), 0);
        ack = 1'b0;

        // long WAIT with x toggling, then ack with x=1, then fresh pattern
        expect_run(3, 16);
        send_pattern();
        send_delay(4'd3);
        x = 1'b0;
        wait_done(20);
        tog = 16'b1101_1101_0110_1101;
        for (int i = 0; i < 50; i++) begin
            x = tog[i % 16];
            tick();
            chk("wait_hold", int'({done, shift_ena}), 2);
        end
        x = 1'b1;
        ack = 1'b1;
        tick();
        chk("wait_ack_drop", int'(done), 0);
        ack = 1'b0;
        no_match_bits_101();
        send(1'b0);
        run(4'd1, 8);

        // async reset mid-SHIFT
        send_pattern();
        send(1'b1);
        send(1'b0);
        #2 reset = 1'b1;
        #1 check_idle_outputs("rst_shift");
        @(negedge clk);
        #2 reset = 1'b0;
        no_match_bits_101();
        send(1'b0);
        run(4'd2, 12);

        // async reset mid-COUNT
        send_pattern();
        send_delay(4'd5);
        x = 1'b0;
        repeat (6) tick();
        #2 reset = 1'b1;
        #1 check_idle_outputs("rst_count");
        @(negedge clk);
        #2 reset = 1'b0;
        no_match_bits_101();
        send(1'b0);
        run(4'd0, 4);

        // back-to-back runs
        run(4'd2, 12);
        run(4'd1, 8);

        repeat (5) tick();
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
